// File: rtl/mem_dma_copy_if.sv
// Memory-controller burst bus (AR/R/AW/W/B) between the DMA master and a memory slave.
interface mem_dma_copy_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [1:0]        r_resp;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;

  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  modport master (
    output ar_valid, ar_addr, ar_len, input ar_ready,
    input  r_valid, r_data, r_last, r_resp, output r_ready,
    output aw_valid, aw_addr, aw_len, input aw_ready,
    output w_valid, w_data, w_last, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, output ar_ready,
    output r_valid, r_data, r_last, r_resp, input r_ready,
    input  aw_valid, aw_addr, aw_len, output aw_ready,
    input  w_valid, w_data, w_last, output w_ready,
    output b_valid, b_resp, input b_ready
  );
endinterface

// File: rtl/mem_dma_copy.sv
// Single-command memory copy engine: read chunk -> buffer -> write chunk, repeated
// until the word count is exhausted or an error response is seen.
// Optional fill mode (write cmd_pattern, no reads) is enabled by defining MEM_DMA_FILL_EN.
module mem_dma_copy #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [CNT_W-1:0]  cmd_words,
  input  logic              cmd_fill,
  input  logic [DATA_W-1:0] cmd_pattern,
  output logic              busy,
  output logic              done_valid,
  output logic              done_err,
  output logic [CNT_W-1:0]  done_words,
  mem_dma_copy_if.master    bus
);

  localparam int unsigned IDX_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int unsigned BYTES = DATA_W / 8;

`ifdef MEM_DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_RD, S_AW, S_WR, S_BR, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [CNT_W-1:0]    wcount_q, wcount_d;
  logic                err_q, err_d;
  logic                fill_q, fill_d;
  logic [DATA_W-1:0]   pattern_q, pattern_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]   chunk_q [MAX_BURST];
  logic [DATA_W-1:0]   chunk_d [MAX_BURST];

  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                done_valid_q, done_valid_d;
  logic                done_err_q, done_err_d;
  logic [CNT_W-1:0]    done_words_q, done_words_d;
  logic                ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]          ar_len_q, ar_len_d;
  logic                r_ready_q, r_ready_d;
  logic                aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [7:0]          aw_len_q, aw_len_d;
  logic                w_valid_q, w_valid_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic                w_last_q, w_last_d;
  logic                b_ready_q, b_ready_d;

  logic [CNT_W-1:0]    n_cur;
  logic [CNT_W-1:0]    n_next;

  // Beats in the next chunk: min(remaining, MAX_BURST)
  function automatic logic [CNT_W-1:0] chunk_len(input logic [CNT_W-1:0] rem);
    if (rem > CNT_W'(MAX_BURST)) begin
      chunk_len = CNT_W'(MAX_BURST);
    end else begin
      chunk_len = rem;
    end
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    remain_d  = remain_q;
    wcount_d  = wcount_q;
    err_d     = err_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    rd_idx_d  = rd_idx_q;
    wr_idx_d  = wr_idx_q;
    chunk_d   = chunk_q;
    n_cur     = chunk_len(remain_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          src_d     = cmd_src;
          dst_d     = cmd_dst;
          remain_d  = cmd_words;
          wcount_d  = '0;
          err_d     = 1'b0;
          fill_d    = FILL_EN && cmd_fill;
          pattern_d = cmd_pattern;
          rd_idx_d  = '0;
          wr_idx_d  = '0;
          if (cmd_words == '0) begin
            state_d = S_DONE;
          end else if (fill_d) begin
            state_d = S_AW;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (ar_valid_q && bus.ar_ready) begin
          rd_idx_d = '0;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        if (bus.r_valid && r_ready_q) begin
          chunk_d[rd_idx_q] = bus.r_data;
          if (rd_idx_q != IDX_W'(MAX_BURST - 1)) begin
            rd_idx_d = IDX_W'(rd_idx_q + 1'b1);
          end
          if (bus.r_resp != 2'b00) begin
            err_d = 1'b1;
          end
          // The responder may cut a burst short with an error beat, so r_last ends the phase
          if (bus.r_last) begin
            state_d = err_d ? S_DONE : S_AW;
          end
        end
      end
      S_AW: begin
        if (aw_valid_q && bus.aw_ready) begin
          wr_idx_d = '0;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        // An early write response means the address was rejected; stop sending data
        if (bus.b_valid) begin
          state_d = S_BR;
        end else if (w_valid_q && bus.w_ready) begin
          if (wr_idx_q == IDX_W'(n_cur - CNT_W'(1))) begin
            state_d = S_BR;
          end else begin
            wr_idx_d = IDX_W'(wr_idx_q + 1'b1);
          end
        end
      end
      S_BR: begin
        if (bus.b_valid && b_ready_q) begin
          if (bus.b_resp == 2'b00) begin
            wcount_d = wcount_q + n_cur;
          end else begin
            err_d = 1'b1;
          end
          src_d    = src_q + ADDR_W'(32'(n_cur) * BYTES);
          dst_d    = dst_q + ADDR_W'(32'(n_cur) * BYTES);
          remain_d = remain_q - n_cur;
          rd_idx_d = '0;
          if (err_d || (remain_d == '0)) begin
            state_d = S_DONE;
          end else if (fill_q) begin
            state_d = S_AW;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    n_next       = chunk_len(remain_d);
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_valid_d = (state_d == S_DONE);
    done_err_d   = done_valid_d ? err_d : done_err_q;
    done_words_d = done_valid_d ? wcount_d : done_words_q;

    ar_valid_d   = (state_d == S_AR);
    ar_addr_d    = ar_valid_d ? src_d : ar_addr_q;
    ar_len_d     = ar_valid_d ? 8'(n_next - CNT_W'(1)) : ar_len_q;
    r_ready_d    = (state_d == S_RD);

    aw_valid_d   = (state_d == S_AW);
    aw_addr_d    = aw_valid_d ? dst_d : aw_addr_q;
    aw_len_d     = aw_valid_d ? 8'(n_next - CNT_W'(1)) : aw_len_q;

    w_valid_d    = (state_d == S_WR);
    w_data_d     = w_valid_d ? (fill_d ? pattern_d : chunk_d[wr_idx_d]) : w_data_q;
    w_last_d     = w_valid_d && (wr_idx_d == IDX_W'(n_next - CNT_W'(1)));
    b_ready_d    = (state_d == S_BR);
  end

  // Control state and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remain_q     <= '0;
      wcount_q     <= '0;
      err_q        <= 1'b0;
      fill_q       <= 1'b0;
      pattern_q    <= '0;
      rd_idx_q     <= '0;
      wr_idx_q     <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_words_q <= '0;
      ar_valid_q   <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= '0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      aw_len_q     <= '0;
      w_valid_q    <= 1'b0;
      w_data_q     <= '0;
      w_last_q     <= 1'b0;
      b_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remain_q     <= remain_d;
      wcount_q     <= wcount_d;
      err_q        <= err_d;
      fill_q       <= fill_d;
      pattern_q    <= pattern_d;
      rd_idx_q     <= rd_idx_d;
      wr_idx_q     <= wr_idx_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      done_words_q <= done_words_d;
      ar_valid_q   <= ar_valid_d;
      ar_addr_q    <= ar_addr_d;
      ar_len_q     <= ar_len_d;
      r_ready_q    <= r_ready_d;
      aw_valid_q   <= aw_valid_d;
      aw_addr_q    <= aw_addr_d;
      aw_len_q     <= aw_len_d;
      w_valid_q    <= w_valid_d;
      w_data_q     <= w_data_d;
      w_last_q     <= w_last_d;
      b_ready_q    <= b_ready_d;
    end
  end

  // Chunk buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    chunk_q <= chunk_d;
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done_valid   = done_valid_q;
  assign done_err     = done_err_q;
  assign done_words   = done_words_q;
  assign bus.ar_valid = ar_valid_q;
  assign bus.ar_addr  = ar_addr_q;
  assign bus.ar_len   = ar_len_q;
  assign bus.r_ready  = r_ready_q;
  assign bus.aw_valid = aw_valid_q;
  assign bus.aw_addr  = aw_addr_q;
  assign bus.aw_len   = aw_len_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_last   = w_last_q;
  assign bus.b_ready  = b_ready_q;

endmodule
